// File: rtl/peak_pkg.sv
// ---------------------------------------------------------------------------
// peak_pkg -- shared definitions for the peak_detect block.
//   state_t        : window FSM encoding (IDLE / ACCUM / DUMP)
//   *_MIN / *_MAX  : legal ranges for the peak_detect parameters
// ---------------------------------------------------------------------------
package peak_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DUMP  = 2'd2
  } state_t;

  localparam int unsigned W_MIN           = 4;
  localparam int unsigned W_MAX           = 18;
  localparam int unsigned LOG_WIN_MIN     = 1;
  localparam int unsigned LOG_WIN_MAX     = 16;
  localparam int unsigned DECAY_SHIFT_MIN = 1;

endpackage

// File: rtl/peak_detect_abs_sat.sv
// ---------------------------------------------------------------------------
// abs_sat -- registered saturating magnitude of a two's-complement sample.
// The most negative input maps to the largest positive W-1 bit value rather
// than wrapping to zero.
//   clk, rst  : clock, synchronous active-high reset
//   i_valid   : sample qualifier
//   i_flush   : drop any registered sample (takes priority over i_valid)
//   i_sig     : W-bit signed sample
//   o_mag     : W-1 bit unsigned magnitude
//   o_valid   : o_mag holds a fresh magnitude this cycle
// ---------------------------------------------------------------------------
module abs_sat
  import peak_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic         i_flush,
  input  logic [W-1:0] i_sig,
  output logic [W-2:0] o_mag,
  output logic         o_valid
);

  logic [W-2:0] w_neg;
  logic [W-2:0] w_abs;
  logic         w_is_min;
  logic [W-2:0] r_mag;
  logic         r_valid;

  // Negating only the low bits is exact modulo 2^(W-1) for every negative
  // input except the most negative one, which is handled by w_is_min.
  assign w_neg    = (W-1)'(0) - i_sig[W-2:0];
  assign w_is_min = i_sig[W-1] && (i_sig[W-2:0] == '0);

  always_comb begin
    w_abs = i_sig[W-2:0];
    if (w_is_min) begin
      w_abs = '1;
    end else if (i_sig[W-1]) begin
      w_abs = w_neg;
    end
  end

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid && !i_flush;
      if (i_valid && !i_flush) begin
        r_mag <= w_abs;
      end
    end
  end

  assign o_mag   = r_mag;
  assign o_valid = r_valid;

endmodule

// File: rtl/peak_detect.sv
// ---------------------------------------------------------------------------
// peak_detect -- windowed peak-magnitude detector.
// Tracks the maximum |sig| over windows of 2^LOG_WIN accepted samples and
// publishes it with a one-cycle strobe, three clocks after the final sample.
// Optional feature macro: PEAK_DECAY_EN (decaying peak-hold output).
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : sig qualifier
//   sig         : W-bit two's-complement sample
//   clear       : abort the current window without publishing
//   peak        : maximum magnitude of the last completed window
//   peak_valid  : one-cycle strobe, new peak/hold present
//   hold        : peak-hold value (equals peak without PEAK_DECAY_EN)
//   active      : a window has accepted at least one sample
// ---------------------------------------------------------------------------
module peak_detect
  import peak_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned LOG_WIN     = 10,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] sig,
  input  logic         clear,
  output logic [W-2:0] peak,
  output logic         peak_valid,
  output logic [W-2:0] hold,
  output logic         active
);

  // Elaboration-time parameter range checks
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("peak_detect: W out of range");
  end
  if (LOG_WIN < LOG_WIN_MIN || LOG_WIN > LOG_WIN_MAX) begin : g_bad_log_win
    $error("peak_detect: LOG_WIN out of range");
  end
  if (DECAY_SHIFT < DECAY_SHIFT_MIN || DECAY_SHIFT > W - 2) begin : g_bad_shift
    $error("peak_detect: DECAY_SHIFT out of range");
  end

  logic [W-2:0]       w_mag;
  logic               w_mag_valid;
  logic               w_borrow;
  logic [W-2:0]       w_unused_rem;
  logic               w_absorb;
  logic               w_restart;
  logic               w_publish;
  state_t             r_state;
  state_t             w_next;
  logic [W-2:0]       r_max;
  logic [LOG_WIN-1:0] r_count;
  logic [W-2:0]       r_peak;
  logic               r_peak_valid;
  logic               r_active;

  // Stage 1: saturating magnitude
  abs_sat #(
    .W (W)
  ) u_abs_sat (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .i_flush (clear),
    .i_sig   (sig),
    .o_mag   (w_mag),
    .o_valid (w_mag_valid)
  );

  // Stage 2 comparator: borrow out of (m - mag) means mag > m; equal gives no borrow
  assign {w_borrow, w_unused_rem} = {1'b0, r_max} - {1'b0, w_mag};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_mag_valid) w_next = ST_ACCUM;
        ST_ACCUM: if (w_mag_valid && (&r_count)) w_next = ST_DUMP;
        ST_DUMP:  w_next = w_mag_valid ? ST_ACCUM : ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // FSM datapath controls; restart loads m/count from the arriving sample (or 0)
  always_comb begin
    w_absorb  = 1'b0;
    w_restart = 1'b0;
    w_publish = 1'b0;
    if (!clear) begin
      case (r_state)
        ST_IDLE:  w_restart = 1'b1;
        ST_ACCUM: w_absorb  = w_mag_valid;
        ST_DUMP: begin
          w_publish = 1'b1;
          w_restart = 1'b1;
        end
        default: w_restart = 1'b1;
      endcase
    end
  end

  // Running max, sample counter and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max        <= '0;
      r_count      <= '0;
      r_peak       <= '0;
      r_peak_valid <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_peak_valid <= w_publish;
      r_active     <= (w_next == ST_ACCUM);
      if (w_publish) begin
        r_peak <= r_max;
      end
      if (clear) begin
        r_max   <= '0;
        r_count <= '0;
      end else if (w_restart) begin
        r_max   <= w_mag_valid ? w_mag : '0;
        r_count <= w_mag_valid ? LOG_WIN'(1) : '0;
      end else if (w_absorb) begin
        if (w_borrow) begin
          r_max <= w_mag;
        end
        r_count <= r_count + LOG_WIN'(1);
      end
    end
  end

`ifdef PEAK_DECAY_EN
  logic [W-2:0] r_hold;
  logic [W-2:0] w_decayed;
  logic [W-2:0] w_hold_next;

  // Hold decays by hold>>DECAY_SHIFT per published window unless a larger peak arrives
  assign w_decayed   = r_hold - (r_hold >> DECAY_SHIFT);
  assign w_hold_next = (r_max > w_decayed) ? r_max : w_decayed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_publish) begin
      r_hold <= w_hold_next;
    end
  end

  assign hold = r_hold;
`else
  assign hold = r_peak;
`endif

  assign peak       = r_peak;
  assign peak_valid = r_peak_valid;
  assign active     = r_active;

endmodule

// File: tb/tb_peak_detect.sv
// ---------------------------------------------------------------------------
// tb_peak_detect -- self-checking bench for peak_detect (W=8, LOG_WIN=2).
// Per-cycle vector table plus hand sequences for reset mid-window and the
// window latency / hold behaviour.
// ---------------------------------------------------------------------------
module tb_peak_detect;

  localparam int unsigned W           = 8;
  localparam int unsigned LOG_WIN     = 2;
  localparam int unsigned DECAY_SHIFT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] sig = '0;
  logic         clear = 1'b0;
  logic [W-2:0] peak;
  logic         peak_valid;
  logic [W-2:0] hold;
  logic         active;

  int n_checks = 0;
  int n_fail   = 0;

  peak_detect #(
    .W           (W),
    .LOG_WIN     (LOG_WIN),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sig        (sig),
    .clear      (clear),
    .peak       (peak),
    .peak_valid (peak_valid),
    .hold       (hold),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   s;
    logic c;
    logic pv;
    int   pk;
    logic act;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic v, input int s, input logic c,
                     input logic pv, input int pk, input logic act);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.pv = pv; t.pk = pk; t.act = act;
    tbl.push_back(t);
  endtask

  // Feed one 4-sample window back to back, then expect the strobe on the
  // second edge after the final-sample edge (3 clocks after its cycle).
  task automatic run_window(input int s0, input int s1, input int s2, input int s3,
                            input int exp_peak, input int exp_hold);
    int smp[4];
    int n;
    bit seen;
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sig      = W'(smp[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    sig      = '0;
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (peak_valid) begin
        seen = 1'b1;
        n    = k;
      end
    end
    chk("win_strobe_seen", int'(seen), 1);
    if (seen) begin
      chk("win_latency", n, 2);
      chk("win_peak", int'(peak), exp_peak);
      chk("win_hold", int'(hold), exp_hold);
      @(posedge clk); #1;
      chk("win_strobe_one_cycle", int'(peak_valid), 0);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_peak", int'(peak), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_pv", int'(peak_valid), 0);
    chk("rst_active", int'(active), 0);
    @(negedge clk);
    rst = 1'b0;

    // v, sig, clear | expected after the edge: peak_valid, peak, active
    // Window 5,-20,7,3 -> 20
    add(1,   5, 0, 0,   0, 0);
    add(1, -20, 0, 0,   0, 1);
    add(1,   7, 0, 0,   0, 1);
    add(1,   3, 0, 0,   0, 1);
    add(0,   0, 0, 0,   0, 0);
    add(0,   0, 0, 1,  20, 0);
    add(0,   0, 0, 0,  20, 0);
    // Most negative sample saturates to 127
    add(1, -128, 0, 0, 20, 0);
    add(1,   1, 0, 0,  20, 1);
    add(1,   2, 0, 0,  20, 1);
    add(1,   3, 0, 0,  20, 1);
    add(0,   0, 0, 0,  20, 0);
    add(0,   0, 0, 1, 127, 0);
    add(0,   0, 0, 0, 127, 0);
    // Continuous stream: back-to-back windows 4 then 9
    add(1,   1, 0, 0, 127, 0);
    add(1,   2, 0, 0, 127, 1);
    add(1,   3, 0, 0, 127, 1);
    add(1,   4, 0, 0, 127, 1);
    add(1,   9, 0, 0, 127, 0);
    add(1,   1, 0, 1,   4, 1);
    add(1,   1, 0, 0,   4, 1);
    add(1,   1, 0, 0,   4, 1);
    add(0,   0, 0, 0,   4, 0);
    add(0,   0, 0, 1,   9, 0);
    add(0,   0, 0, 0,   9, 0);
    // clear after 3 samples (max 50); clear beats a simultaneous sample of 99
    add(1,  50, 0, 0,   9, 0);
    add(1,  20, 0, 0,   9, 1);
    add(1,  30, 0, 0,   9, 1);
    add(1,  99, 1, 0,   9, 0);
    add(1,  10, 0, 0,   9, 0);
    add(1,  11, 0, 0,   9, 1);
    add(1,  12, 0, 0,   9, 1);
    add(1,  13, 0, 0,   9, 1);
    add(0,   0, 0, 0,   9, 0);
    add(0,   0, 0, 1,  13, 0);
    add(0,   0, 0, 0,  13, 0);
    // clear during DUMP suppresses the strobe
    add(1,   1, 0, 0,  13, 0);
    add(1,   2, 0, 0,  13, 1);
    add(1,   3, 0, 0,  13, 1);
    add(1,  40, 0, 0,  13, 1);
    add(0,   0, 0, 0,  13, 0);
    add(0,   0, 1, 0,  13, 0);
    add(0,   0, 0, 0,  13, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      sig      = W'(tbl[i].s);
      clear    = tbl[i].c;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pv", i), int'(peak_valid), int'(tbl[i].pv));
      chk($sformatf("v%0d_peak", i), int'(peak), tbl[i].pk);
      chk($sformatf("v%0d_active", i), int'(active), int'(tbl[i].act));
`ifndef PEAK_DECAY_EN
      chk($sformatf("v%0d_hold", i), int'(hold), tbl[i].pk);
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    sig      = '0;

    // rst during ACCUM (max 60) dominates clear and in_valid, no strobe
    @(negedge clk); in_valid = 1'b1; sig = W'(60);
    @(negedge clk); in_valid = 1'b1; sig = W'(5);
    @(posedge clk); #1;
    chk("mid_active_before_rst", int'(active), 1);
    @(negedge clk); rst = 1'b1; clear = 1'b1; in_valid = 1'b1; sig = W'(70);
    @(posedge clk); #1;
    chk("mid_rst_pv", int'(peak_valid), 0);
    chk("mid_rst_peak", int'(peak), 0);
    chk("mid_rst_hold", int'(hold), 0);
    chk("mid_rst_active", int'(active), 0);
    @(negedge clk); rst = 1'b0; clear = 1'b0; in_valid = 1'b0; sig = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_pv%0d", k), int'(peak_valid), 0);
      chk($sformatf("post_rst_active%0d", k), int'(active), 0);
    end

    // Window peaking 100, then all-zero windows
`ifdef PEAK_DECAY_EN
    run_window(100, 0, -3, 7, 100, 100);
    run_window(0, 0, 0, 0, 0, 88);
    run_window(0, 0, 0, 0, 0, 77);
    run_window(0, 0, 0, 0, 0, 68);
`else
    run_window(100, 0, -3, 7, 100, 100);
    run_window(0, 0, 0, 0, 0, 0);
    run_window(-100, 100, -100, 99, 100, 100);
    run_window(0, 0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_detect.md
PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 Parameter W, default 8, signed input width (4..18).
REQ-002 Parameter LOG_WIN, default 10, window length 2^LOG_WIN accepted samples (1..16).
REQ-003 Parameter DECAY_SHIFT, default 3, hold-decay shift per window (1..W-2); used only with PEAK_DECAY_EN.
REQ-004 clk  in  1  master clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  sig qualifier; one sample per cycle when high.
REQ-007 sig  in  W  two's-complement sample.
REQ-008 clear  in  1  abort current window, restart counting; no result emitted.
REQ-009 peak  out  W-1  unsigned maximum magnitude of last completed window.
REQ-010 peak_valid  out  1  one-cycle strobe: new peak (and hold) value present.
REQ-011 hold  out  W-1  peak-hold value (equals peak when PEAK_DECAY_EN undefined).
REQ-012 active  out  1  high while a window has accepted at least one sample.

Function
REQ-013 Stage 1 SHALL register |sig| for each valid sample; -2^(W-1) saturates to 2^(W-1)-1 (no wrap to 0).
REQ-014 Stage 2 SHALL compare the stage-1 magnitude against running max m via subtract-borrow, m <= mag when mag > m.
REQ-015 Sample counter SHALL count stage-1 valid magnitudes, modulo 2^LOG_WIN.
REQ-016 FSM states: IDLE (m=0, count=0), ACCUM (counting), DUMP (one cycle, publish).
REQ-017 IDLE->ACCUM on first valid magnitude; ACCUM->DUMP when the 2^LOG_WIN-th magnitude is absorbed; DUMP->ACCUM if a valid magnitude arrives that cycle, else IDLE.
REQ-018 In DUMP: peak <= max including final sample, peak_valid=1, m restarted from the magnitude arriving that cycle (or 0); no sample lost across window boundaries.
REQ-019 Latency: peak_valid asserts exactly 3 clk after the cycle the final sample had in_valid=1.
REQ-020 Gaps in in_valid SHALL stall the window without altering m or count.
REQ-021 clear SHALL force IDLE, m=0, count=0, flush stage 1, suppress pending DUMP; peak/hold retain last values; clear wins over simultaneous in_valid.
REQ-022 Equal magnitudes (mag == m) SHALL NOT count as a new max (no update).
REQ-023 peak_valid SHALL never assert on consecutive cycles when LOG_WIN >= 1.

Reset
REQ-024 rst SHALL set FSM=IDLE, m=0, count=0, stage-1 valid=0, peak=0, hold=0, peak_valid=0, active=0.
REQ-025 rst mid-window SHALL discard the partial window with no peak_valid strobe; rst dominates clear and in_valid.

Configuration
REQ-026 Macro PEAK_DECAY_EN: when defined, at each DUMP hold <= max(peak_new, hold - (hold >> DECAY_SHIFT)).
REQ-027 Without PEAK_DECAY_EN, hold SHALL equal peak every cycle and no decay logic is synthesised.

Structure
REQ-028 Shared package peak_pkg SHALL hold FSM state encoding (IDLE, ACCUM, DUMP) and parameter range-limit constants.
REQ-029 Sub-module abs_sat (W in, W-1 out, registered, saturating magnitude) SHALL implement stage 1.
REQ-030 No multipliers or RAM; comparator SHALL use subtract-borrow, single carry chain.

Verification
REQ-031 W=8, LOG_WIN=2; samples 5,-20,7,3 -> peak=20, peak_valid 3 cycles after sample 4.
REQ-032 W=8; sample -128 within a window -> peak=127, not 0.
REQ-033 LOG_WIN=2; continuous stream 1,2,3,4,9,1,1,1 -> peaks 4 then 9, back-to-back windows, no lost sample.
REQ-034 clear asserted after 3 of 4 samples (max 50), then 10,11,12,13 -> single peak_valid, peak=13.
REQ-035 PEAK_DECAY_EN, DECAY_SHIFT=3; window peak 100 then windows peaking 0 -> hold 100, 88, 77, 68.
REQ-036 rst during ACCUM with max 60 -> no strobe; peak=0, hold=0, active=0 next cycle.
